// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
//
// Multi-cycle restoring divider with four operations: signed/unsigned quotient
// and signed/unsigned remainder. A normal operation takes one RUN cycle per
// result bit, then one FIX cycle to restore signs, then a one-cycle DONE pulse.
// Divide-by-zero and signed overflow skip RUN and finish two cycles after the
// start is accepted.
//
// Ports
//   clk       single clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request a new operation (honoured only when idle)
//   op        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  dividend operand, N bits
//   divisor   divisor operand, N bits
//   abort     cancel the operation while it is iterating or fixing up
//   busy      high while an operation is in flight
//   done      one-cycle completion pulse
//   result    selected quotient or remainder, held until the next completion
// -----------------------------------------------------------------------------
module div_sequencer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_DIV = 2'b00;
    localparam logic [1:0] OP_REM = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             bypass_q, bypass_d;
    logic [N-1:0]     dvs_q, dvs_d;
    logic [N:0]       rem_q, rem_d;
    logic [N-1:0]     quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     result_q, result_d;

    logic             op_signed;
    logic             dividend_neg;
    logic             divisor_neg;
    logic             div_by_zero;
    logic             overflow;
    logic [N-1:0]     special_val;
    logic [N+1:0]     shifted;
    logic [N+1:0]     trial;
    logic [N-1:0]     quo_fix;
    logic [N-1:0]     rem_fix;

    // Operand classification; bit 0 of op selects the unsigned variants.
    assign op_signed    = ~op[0];
    assign dividend_neg = op_signed & dividend[N-1];
    assign divisor_neg  = op_signed & divisor[N-1];
    assign div_by_zero  = (divisor == '0);
    assign overflow     = op_signed && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);

    // Result for the two bypass cases; bit 1 of op selects a remainder result.
    always_comb begin
        special_val = '0;
        if (div_by_zero) begin
            special_val = op[1] ? dividend : '1;
        end else begin
            special_val = op[1] ? '0 : dividend;
        end
    end

    // One restoring step. The trial is kept one bit wider than the remainder
    // register so its top bit is the borrow that decides whether to restore.
    assign shifted = {rem_q, quo_q[N-1]};
    assign trial   = shifted - {2'b00, dvs_q};

    // Sign restoration from the magnitudes produced by the iteration.
    assign quo_fix = ((op_q == OP_DIV) && (sign_a_q != sign_b_q)) ? -quo_q : quo_q;
    assign rem_fix = ((op_q == OP_REM) && sign_a_q) ? -rem_q[N-1:0] : rem_q[N-1:0];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        bypass_d = bypass_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op;
                    sign_a_d = dividend_neg;
                    sign_b_d = divisor_neg;
                    dvs_d    = divisor_neg ? -divisor : divisor;
                    rem_d    = '0;
                    cnt_d    = '0;
                    if (div_by_zero || overflow) begin
                        // The quotient register is idle on the bypass path,
                        // so it carries the precomputed answer to FIX.
                        bypass_d = 1'b1;
                        quo_d    = special_val;
                        state_d  = S_FIX;
                    end else begin
                        bypass_d = 1'b0;
                        quo_d    = dividend_neg ? -dividend : dividend;
                        state_d  = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (trial[N+1] == 1'b0) begin
                        rem_d = trial[N:0];
                        quo_d = {quo_q[N-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[N:0];
                        quo_d = {quo_q[N-2:0], 1'b0};
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_FIX: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (bypass_q) begin
                        result_d = quo_q;
                    end else begin
                        result_d = op_q[1] ? rem_fix : quo_fix;
                    end
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            bypass_q <= 1'b0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            bypass_q <= bypass_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-005 The block SHALL have port op, input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 The block SHALL have port dividend, input, N bits: the dividend operand.
REQ-007 The block SHALL have port divisor, input, N bits: the divisor operand.
REQ-008 The block SHALL have port abort, input, 1 bit: cancel the operation in progress.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port result, output, N bits: the quotient or remainder selected by op.

Function
REQ-012 The block SHALL implement the FSM states IDLE, RUN, FIX and DONE.
REQ-013 In IDLE with start=1, the block SHALL, at the rising edge, capture op, capture the absolute values of dividend and divisor (absolute values only for DIV/REM; raw values for DIVU/REMU), record both operand signs, clear the remainder register (N+1 bits) and the step counter, and go to RUN.
REQ-014 start SHALL be ignored while not in IDLE, and no operand register SHALL change.
REQ-015 In RUN, each cycle the block SHALL perform exactly one restoring step: shift {rem, quo} left, bring down the quotient MSB, subtract {0,divisor}, keep the difference and shift in 1 if its MSB is 0, otherwise keep the shifted remainder and shift in 0.
REQ-016 RUN SHALL last exactly N cycles, with the counter counting 0..N-1, and then the block SHALL go to FIX.
REQ-017 In FIX, the block SHALL negate the quotient when the signs differ (DIV only) and negate the remainder when the dividend was negative (REM only); it SHALL then register result and go to DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-019 For a normal operation, done SHALL be high in cycle k+N+2, where k is the start-accept edge; result SHALL hold its value until the next start is accepted.
REQ-020 For divide-by-zero (divisor=0), the block SHALL bypass RUN: go from IDLE to FIX, then DONE, with result = all ones for DIV/DIVU and result = dividend for REM/REMU; done SHALL be high in cycle k+2.
REQ-021 For signed overflow (DIV/REM, dividend=2^(N-1) pattern, divisor=all ones), the block SHALL bypass RUN with result = dividend for DIV and result = 0 for REM; done SHALL be high in cycle k+2.
REQ-022 busy SHALL be 1 in RUN, FIX and DONE, and 0 in IDLE.
REQ-023 abort=1 in RUN or FIX SHALL force IDLE at the next edge, with no done pulse and result unchanged; abort in IDLE or DONE SHALL have no effect.
REQ-024 When abort and start are both 1 in IDLE, start SHALL win.
REQ-025 All arithmetic SHALL be modulo 2^N; negation SHALL be two's complement.

Reset
REQ-026 rst_n=0 SHALL force the state to IDLE and busy=0, done=0, result=0, counter=0, and the remainder and quotient registers to 0, asynchronously.
REQ-027 Reset asserted mid-operation SHALL discard the operation with no done pulse; the first start after rst_n rises SHALL behave normally.

Verification
REQ-028 DIVU 100/7, start pulse: busy rises next cycle; done pulses exactly N+2 cycles after accept; result=14; REMU with the same operands gives result=2.
REQ-029 DIV -7/2 gives result=-3 (0xFFFFFFFD); REM -7/2 gives result=-1; DIV 7/-2 gives result=-3; REM 7/-2 gives result=1.
REQ-030 DIVU 5/0 gives result=0xFFFFFFFF and REMU 5/0 gives result=5, each with done 2 cycles after accept; DIV 0x80000000/0xFFFFFFFF gives result=0x80000000, and REM with the same operands gives result=0.
REQ-031 start re-pulsed with different operands during RUN: the response is ignored and the original result is returned with correct latency.
REQ-032 abort at RUN step 10: IDLE next cycle with no done and result unchanged; the subsequent DIVU 9/3 gives result=3.
REQ-033 rst_n pulsed low at RUN step 5: outputs are cleared immediately and no done follows; the subsequent operation is correct.
